// File: rtl/sw_array_scheduler_if.sv
// Handshake and bus bundle between the Smith-Waterman scheduler (slave) and
// the host/DMA plus PE-chain side (master).
interface sw_array_scheduler_if #(
   parameter int SCORE_WIDTH = 12
);
   logic                   start_i;
   logic [SCORE_WIDTH-1:0] cfg_match_i;
   logic [SCORE_WIDTH-1:0] cfg_mismatch_i;
   logic [SCORE_WIDTH-1:0] cfg_gap_open_i;
   logic [SCORE_WIDTH-1:0] cfg_gap_extend_i;
   logic                   q_valid_i;
   logic [1:0]             q_base_i;
   logic                   q_ready_o;
   logic                   t_valid_i;
   logic [1:0]             t_base_i;
   logic                   t_last_i;
   logic                   t_ready_o;
   logic                   pe_en_o;
   logic [1:0]             pe_data_o;
   logic                   q_shift_en_o;
   logic [1:0]             q_shift_base_o;
   logic [SCORE_WIDTH-1:0] lut_match_o;
   logic [SCORE_WIDTH-1:0] lut_mismatch_o;
   logic [SCORE_WIDTH-1:0] lut_gap_open_o;
   logic [SCORE_WIDTH-1:0] lut_gap_extend_o;
   logic                   arr_vld_i;
   logic [SCORE_WIDTH-1:0] arr_high_i;
   logic                   res_valid_o;
   logic                   res_ready_i;
   logic [SCORE_WIDTH-1:0] res_score_o;
   logic                   err_underrun_o;
   logic                   err_timeout_o;
   logic                   busy_o;
   logic [31:0]            cyc_count_o;

   modport slave (
      input  start_i, cfg_match_i, cfg_mismatch_i, cfg_gap_open_i, cfg_gap_extend_i,
      input  q_valid_i, q_base_i, t_valid_i, t_base_i, t_last_i,
      input  arr_vld_i, arr_high_i, res_ready_i,
      output q_ready_o, t_ready_o, pe_en_o, pe_data_o, q_shift_en_o, q_shift_base_o,
      output lut_match_o, lut_mismatch_o, lut_gap_open_o, lut_gap_extend_o,
      output res_valid_o, res_score_o, err_underrun_o, err_timeout_o, busy_o, cyc_count_o
   );

   modport master (
      output start_i, cfg_match_i, cfg_mismatch_i, cfg_gap_open_i, cfg_gap_extend_i,
      output q_valid_i, q_base_i, t_valid_i, t_base_i, t_last_i,
      output arr_vld_i, arr_high_i, res_ready_i,
      input  q_ready_o, t_ready_o, pe_en_o, pe_data_o, q_shift_en_o, q_shift_base_o,
      input  lut_match_o, lut_mismatch_o, lut_gap_open_o, lut_gap_extend_o,
      input  res_valid_o, res_score_o, err_underrun_o, err_timeout_o, busy_o, cyc_count_o
   );
endinterface

// File: rtl/sw_array_scheduler.sv
// Job sequencer for one linear Smith-Waterman PE chain: query load, target burst, drain, result.
// Optional job cycle counter is built only when SW_ARRAY_CYCLE_COUNT_EN is defined.
module sw_array_scheduler #(
   parameter int N_PE        = 16,
   parameter int SCORE_WIDTH = 12,
   parameter int LEN_WIDTH   = 16
) (
   input logic                 clk,
   input logic                 rst,
   sw_array_scheduler_if.slave bus
);
   localparam logic [4:0] IDLE   = 5'b00001;
   localparam logic [4:0] LOAD_Q = 5'b00010;
   localparam logic [4:0] STREAM = 5'b00100;
   localparam logic [4:0] DRAIN  = 5'b01000;
   localparam logic [4:0] DONE   = 5'b10000;

   localparam int QCNT_W  = $clog2(N_PE + 1);
   localparam int TIMEOUT = 3 * N_PE + 8;
   localparam int TMR_W   = $clog2(TIMEOUT + 1);

   logic [4:0]             state_q, state_d;
   logic [QCNT_W-1:0]      qCnt_q, qCnt_d;
   logic [LEN_WIDTH-1:0]   tLen_q, tLen_d;
   logic [TMR_W-1:0]       timer_q, timer_d;
   logic [SCORE_WIDTH-1:0] lutMatch_q, lutMatch_d;
   logic [SCORE_WIDTH-1:0] lutMismatch_q, lutMismatch_d;
   logic [SCORE_WIDTH-1:0] lutGapOpen_q, lutGapOpen_d;
   logic [SCORE_WIDTH-1:0] lutGapExtend_q, lutGapExtend_d;
   logic                   errUnderrun_q, errUnderrun_d;
   logic                   errTimeout_q, errTimeout_d;
   logic [SCORE_WIDTH-1:0] resScore_q, resScore_d;
   logic                   peEn_q, peEn_d;
   logic [1:0]             peData_q, peData_d;
   logic                   qShiftEn_q, qShiftEn_d;
   logic [1:0]             qShiftBase_q, qShiftBase_d;

   // tLen is non-zero once the burst has begun, so a gap before the first base is a wait, not an underrun.
   always_comb begin
      state_d        = state_q;
      qCnt_d         = qCnt_q;
      tLen_d         = tLen_q;
      timer_d        = timer_q;
      lutMatch_d     = lutMatch_q;
      lutMismatch_d  = lutMismatch_q;
      lutGapOpen_d   = lutGapOpen_q;
      lutGapExtend_d = lutGapExtend_q;
      errUnderrun_d  = errUnderrun_q;
      errTimeout_d   = errTimeout_q;
      resScore_d     = resScore_q;
      peEn_d         = 1'b0;
      peData_d       = peData_q;
      qShiftEn_d     = 1'b0;
      qShiftBase_d   = qShiftBase_q;
      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               lutMatch_d     = bus.cfg_match_i;
               lutMismatch_d  = bus.cfg_mismatch_i;
               lutGapOpen_d   = bus.cfg_gap_open_i;
               lutGapExtend_d = bus.cfg_gap_extend_i;
               errUnderrun_d  = 1'b0;
               errTimeout_d   = 1'b0;
               qCnt_d         = QCNT_W'(N_PE);
               tLen_d         = '0;
               state_d        = LOAD_Q;
            end
         end
         LOAD_Q: begin
            if (bus.q_valid_i) begin
               qShiftEn_d   = 1'b1;
               qShiftBase_d = bus.q_base_i;
               qCnt_d       = qCnt_q - QCNT_W'(1);
               if (qCnt_q == QCNT_W'(1)) begin
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            if (bus.t_valid_i) begin
               peEn_d   = 1'b1;
               peData_d = bus.t_base_i;
               if (tLen_q != '1) begin
                  tLen_d = tLen_q + LEN_WIDTH'(1);
               end
               if (bus.t_last_i) begin
                  timer_d = '0;
                  state_d = DRAIN;
               end
            end else if (tLen_q != '0) begin
               errUnderrun_d = 1'b1;
               timer_d       = '0;
               state_d       = DRAIN;
            end
         end
         DRAIN: begin
            if (bus.arr_vld_i) begin
               resScore_d = bus.arr_high_i[SCORE_WIDTH-1] ?
                            {1'b0, bus.arr_high_i[SCORE_WIDTH-2:0]} : '0;
               state_d    = DONE;
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               errTimeout_d = 1'b1;
               resScore_d   = '0;
               state_d      = DONE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         DONE: begin
            if (bus.res_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= IDLE;
         qCnt_q         <= '0;
         tLen_q         <= '0;
         timer_q        <= '0;
         lutMatch_q     <= '0;
         lutMismatch_q  <= '0;
         lutGapOpen_q   <= '0;
         lutGapExtend_q <= '0;
         errUnderrun_q  <= 1'b0;
         errTimeout_q   <= 1'b0;
         resScore_q     <= '0;
         peEn_q         <= 1'b0;
         peData_q       <= '0;
         qShiftEn_q     <= 1'b0;
         qShiftBase_q   <= '0;
      end else begin
         state_q        <= state_d;
         qCnt_q         <= qCnt_d;
         tLen_q         <= tLen_d;
         timer_q        <= timer_d;
         lutMatch_q     <= lutMatch_d;
         lutMismatch_q  <= lutMismatch_d;
         lutGapOpen_q   <= lutGapOpen_d;
         lutGapExtend_q <= lutGapExtend_d;
         errUnderrun_q  <= errUnderrun_d;
         errTimeout_q   <= errTimeout_d;
         resScore_q     <= resScore_d;
         peEn_q         <= peEn_d;
         peData_q       <= peData_d;
         qShiftEn_q     <= qShiftEn_d;
         qShiftBase_q   <= qShiftBase_d;
      end
   end

   assign bus.q_ready_o        = (state_q == LOAD_Q);
   assign bus.t_ready_o        = (state_q == STREAM);
   assign bus.res_valid_o      = (state_q == DONE);
   assign bus.busy_o           = (state_q != IDLE);
   assign bus.pe_en_o          = peEn_q;
   assign bus.pe_data_o        = peData_q;
   assign bus.q_shift_en_o     = qShiftEn_q;
   assign bus.q_shift_base_o   = qShiftBase_q;
   assign bus.lut_match_o      = lutMatch_q;
   assign bus.lut_mismatch_o   = lutMismatch_q;
   assign bus.lut_gap_open_o   = lutGapOpen_q;
   assign bus.lut_gap_extend_o = lutGapExtend_q;
   assign bus.res_score_o      = resScore_q;
   assign bus.err_underrun_o   = errUnderrun_q;
   assign bus.err_timeout_o    = errTimeout_q;

`ifdef SW_ARRAY_CYCLE_COUNT_EN
   logic [31:0] cycCount_q, cycCount_d;

   // Counting stops once DONE is reached, so the value is frozen while res_valid is high.
   always_comb begin
      cycCount_d = cycCount_q;
      if (state_q == IDLE && bus.start_i) begin
         cycCount_d = '0;
      end else if (state_q == LOAD_Q || state_q == STREAM || state_q == DRAIN) begin
         cycCount_d = cycCount_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cycCount_q <= '0;
      end else begin
         cycCount_q <= cycCount_d;
      end
   end

   assign bus.cyc_count_o = cycCount_q;
`else
   assign bus.cyc_count_o = '0;
`endif
endmodule

// File: tb/tb_sw_array_scheduler.sv
// Directed bench for sw_array_scheduler with a result scoreboard; the bench plays host and PE chain.
module tb_sw_array_scheduler;
   localparam int N_PE    = 4;
   localparam int SW      = 12;
   localparam int ZERO    = 2048;
   localparam int TIMEOUT = 3 * N_PE + 8;

   typedef struct {
      logic [SW-1:0] score;
      logic          underrun;
      logic          timeout;
   } exp_t;

   logic clk;
   logic rst;
   sw_array_scheduler_if #(.SCORE_WIDTH(SW)) bus ();

   sw_array_scheduler #(
      .N_PE       (N_PE),
      .SCORE_WIDTH(SW),
      .LEN_WIDTH  (16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   exp_t       expQ[$];
   int         checkCount = 0;
   int         passCount  = 0;
   int         edgeCnt    = 0;
   int         startEdge  = 0;
   int         qShiftCnt  = 0;
   int         peCnt      = 0;
   logic [7:0] qLog       = '0;
   logic [7:0] peLog      = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, wanted %0d", name, actual, expected);
   endtask

   initial forever begin
      @(posedge clk);
      edgeCnt++;
   end

   // Observe the PE-side outputs away from the active edge and keep running logs.
   initial forever begin
      @(negedge clk);
      if (bus.q_shift_en_o === 1'b1) begin
         qShiftCnt++;
         qLog = {qLog[5:0], bus.q_shift_base_o};
      end
      if (bus.pe_en_o === 1'b1) begin
         peCnt++;
         peLog = {peLog[5:0], bus.pe_data_o};
      end
   end

   // Scoreboard monitor: every accepted result is compared with the oldest expectation.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (bus.res_valid_o === 1'b1 && bus.res_ready_i === 1'b1) begin
         checkOutput("resultExpected", {31'b0, expQ.size() != 0}, 1);
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("resScore", {20'b0, bus.res_score_o}, {20'b0, e.score});
            checkOutput("errUnderrun", {31'b0, bus.err_underrun_o}, {31'b0, e.underrun});
            checkOutput("errTimeout", {31'b0, bus.err_timeout_o}, {31'b0, e.timeout});
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic doReset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetFlags", {24'b0, bus.busy_o, bus.pe_en_o, bus.q_shift_en_o, bus.res_valid_o,
                                 bus.q_ready_o, bus.t_ready_o, bus.err_underrun_o, bus.err_timeout_o}, 0);
      checkOutput("resetLut", {20'b0, bus.lut_match_o | bus.lut_mismatch_o | bus.lut_gap_open_o | bus.lut_gap_extend_o}, 0);
      checkOutput("resetScore", {20'b0, bus.res_score_o}, 0);
      checkOutput("resetCycCount", bus.cyc_count_o, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic setCfg(input int m, input int mm, input int go, input int ge);
      bus.cfg_match_i      = SW'(m);
      bus.cfg_mismatch_i   = SW'(mm);
      bus.cfg_gap_open_i   = SW'(go);
      bus.cfg_gap_extend_i = SW'(ge);
   endtask

   task automatic pulseStart();
      bus.start_i = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      startEdge   = edgeCnt;
   endtask

   task automatic waitReady(input bit isQuery);
      int g = 0;
      @(negedge clk);
      while (!(isQuery ? bus.q_ready_o : bus.t_ready_o) && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) checkOutput(isQuery ? "qReadyWait" : "tReadyWait", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic sendQuery(input logic [7:0] w);
      for (int i = 0; i < N_PE; i++) begin
         bus.q_valid_i = 1'b1;
         bus.q_base_i  = w[7-2*i -: 2];
         waitReady(1'b1);
      end
      bus.q_valid_i = 1'b0;
   endtask

   task automatic sendTarget(input logic [7:0] w, input int n, input bit withLast);
      for (int i = 0; i < n; i++) begin
         bus.t_valid_i = 1'b1;
         bus.t_base_i  = w[7-2*i -: 2];
         bus.t_last_i  = withLast && (i == n - 1);
         waitReady(1'b0);
      end
      bus.t_valid_i = 1'b0;
      bus.t_last_i  = 1'b0;
   endtask

   task automatic respondArray(input int delay, input int high);
      repeat (delay) @(posedge clk);
      #1;
      bus.arr_high_i = SW'(high);
      bus.arr_vld_i  = 1'b1;
      @(posedge clk);
      #1;
      bus.arr_vld_i  = 1'b0;
   endtask

   task automatic waitResult(input bit checkCyc);
      int g = 0;
      int expCyc;
      @(negedge clk);
      while (bus.res_valid_o !== 1'b1 && g < 200) begin
         @(negedge clk);
         g++;
      end
      checkOutput("resValidRises", {31'b0, bus.res_valid_o}, 1);
      if (checkCyc) begin
`ifdef SW_ARRAY_CYCLE_COUNT_EN
         expCyc = edgeCnt - startEdge;
`else
         expCyc = 0;
`endif
         checkOutput("cycCount", bus.cyc_count_o, expCyc);
      end
      g = 0;
      while (bus.busy_o !== 1'b0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      checkOutput("jobCompletes", {31'b0, bus.busy_o}, 0);
      @(posedge clk);
      #1;
   endtask

   // One complete job: configure, load query, stream target, answer as the PE chain.
   task automatic applyStimulus(input logic [7:0] qWord, input logic [7:0] tWord, input int nT,
                                input bit withLast, input int high, input int expScore, input bit expUnder);
      int q0, p0;
      exp_t e;
      pulseStart();
      e.score = SW'(expScore); e.underrun = expUnder; e.timeout = 1'b0;
      expQ.push_back(e);
      q0 = qShiftCnt;
      p0 = peCnt;
      sendQuery(qWord);
      sendTarget(tWord, nT, withLast);
      respondArray(2, high);
      waitResult(1'b1);
      checkOutput("qShiftPulses", qShiftCnt - q0, N_PE);
      checkOutput("qShiftBases", {24'b0, qLog}, {24'b0, qWord});
      checkOutput("peBurstLen", peCnt - p0, nT);
   endtask

   initial begin
      int n;
      exp_t e;
      rst = 1'b0;
      bus.start_i = 1'b0; bus.q_valid_i = 1'b0; bus.q_base_i = '0;
      bus.t_valid_i = 1'b0; bus.t_base_i = '0; bus.t_last_i = 1'b0;
      bus.arr_vld_i = 1'b0; bus.arr_high_i = '0; bus.res_ready_i = 1'b1;
      setCfg(ZERO + 2, ZERO - 1, ZERO - 3, ZERO - 1);
      doReset();

      // Match-only job: AGTC against AGTC scores 4 * 2 = 8.
      applyStimulus(8'h1B, 8'h1B, 4, 1'b1, ZERO + 8, 8, 1'b0);
      checkOutput("lutMatch", {20'b0, bus.lut_match_o}, ZERO + 2);
      checkOutput("lutGapOpen", {20'b0, bus.lut_gap_open_o}, ZERO - 3);
      checkOutput("peData", {24'b0, peLog}, 32'h1B);

      // Underrun: two bases, then t_valid drops on the third STREAM cycle.
      applyStimulus(8'hE4, 8'h50, 2, 1'b0, ZERO + 3, 3, 1'b1);
      checkOutput("underrunPeData", {28'b0, peLog[3:0]}, 32'h5);
      checkOutput("underrunSticky", {31'b0, bus.err_underrun_o}, 1);

      // Drain timeout: the array never reports vld.
      pulseStart();
      checkOutput("underrunCleared", {31'b0, bus.err_underrun_o}, 0);
      e.score = '0; e.underrun = 1'b0; e.timeout = 1'b1;
      expQ.push_back(e);
      bus.arr_high_i = SW'(ZERO + 50);
      sendQuery(8'h1B);
      sendTarget(8'h1B, 4, 1'b1);
      n = 0;
      @(negedge clk);
      while (bus.err_timeout_o !== 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      checkOutput("timeoutCycles", n, TIMEOUT);
      @(posedge clk);
      #1;
      checkOutput("timeoutIdle", {31'b0, bus.busy_o}, 0);
      checkOutput("timeoutSticky", {31'b0, bus.err_timeout_o}, 1);

      // Reset in the middle of STREAM, then a full job with the maximum biased score.
      pulseStart();
      sendQuery(8'h1B);
      sendTarget(8'h1B, 2, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midResetFlags", {29'b0, bus.pe_en_o, bus.busy_o, bus.t_ready_o}, 0);
      checkOutput("midResetLut", {20'b0, bus.lut_match_o | bus.lut_mismatch_o | bus.lut_gap_open_o | bus.lut_gap_extend_o}, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(8'h1B, 8'hFC, 3, 1'b1, 4095, 2047, 1'b0);

      // Start during STREAM is ignored; result held while res_ready stays low; below-zero score clamps.
      pulseStart();
      e.score = '0; e.underrun = 1'b0; e.timeout = 1'b0;
      expQ.push_back(e);
      sendQuery(8'h1B);
      setCfg(ZERO + 12, ZERO - 18, ZERO - 28, ZERO - 8);
      bus.start_i = 1'b1;
      sendTarget(8'h1B, 4, 1'b1);
      bus.start_i = 1'b0;
      setCfg(ZERO + 2, ZERO - 1, ZERO - 3, ZERO - 1);
      checkOutput("lutHeldMatch", {20'b0, bus.lut_match_o}, ZERO + 2);
      checkOutput("lutHeldExtend", {20'b0, bus.lut_gap_extend_o}, ZERO - 1);
      bus.res_ready_i = 1'b0;
      respondArray(2, ZERO - 5);
      n = 0;
      while (bus.res_valid_o !== 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (5) @(posedge clk);
      #1;
      checkOutput("resValidHeld", {31'b0, bus.res_valid_o}, 1);
      checkOutput("busyHeld", {31'b0, bus.busy_o}, 1);
      bus.res_ready_i = 1'b1;
      n = 0;
      while (bus.busy_o !== 1'b0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("releaseIdle", {31'b0, bus.busy_o}, 0);

      repeat (3) @(posedge clk);
      checkOutput("queueDrained", expQ.size(), 0);
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
